// File: rtl/gate_deadtime_monitor.sv
// gate_deadtime_monitor
//   Receive-side checker for one complementary half-bridge gate pair. It
//   synchronizes the high/low gate-driver feedback, measures the dead gap
//   at every H->L and L->H commutation, flags short gaps and shoot-through,
//   and rebuilds the effective PWM.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      monitor enable; 0 parks the tracker in IDLE
//   gate_h      high-side gate feedback (asynchronous)
//   gate_l      low-side gate feedback (asynchronous)
//   min_dead    minimum legal gap in clk cycles (0 disables the check)
//   fault_clr   single-cycle clear of the sticky flags
//   dead_hl     last measured gap, H-off to L-on
//   dead_lh     last measured gap, L-off to H-on
//   meas_valid  1-cycle pulse when dead_hl or dead_lh updates
//   meas_dir    direction of the measurement: 0 = H->L, 1 = L->H
//   pwm_rec     reconstructed PWM, 1 while the high side owns the bridge
//   dead_viol   sticky: a measured gap was shorter than min_dead
//   shoot_fault sticky: both gates were seen high together
module gate_deadtime_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             gate_h,
  input  logic             gate_l,
  input  logic [CNT_W-1:0] min_dead,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] dead_hl,
  output logic [CNT_W-1:0] dead_lh,
  output logic             meas_valid,
  output logic             meas_dir,
  output logic             pwm_rec,
  output logic             dead_viol,
  output logic             shoot_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HIGH  = 3'd1;
  localparam logic [2:0] S_GAP_H = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP_L = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [SYNC_STAGES-1:0] r_sync_h, r_sync_l;
  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_dead_hl, r_dead_lh;
  logic                   r_meas_valid, r_meas_dir, r_pwm, r_viol, r_shoot;

  logic                   w_sh, w_sl, w_shoot;
  logic [2:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt, w_cnt_inc, w_meas_val;
  logic                   w_meas, w_meas_dir, w_pwm_nxt, w_viol_set;

  assign w_sh    = r_sync_h[SYNC_STAGES-1];
  assign w_sl    = r_sync_l[SYNC_STAGES-1];
  assign w_shoot = w_sh & w_sl;

  // Gap counter saturates so an overlong gap reads back as all-ones.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_meas      = 1'b0;
    w_meas_dir  = 1'b0;
    w_meas_val  = '0;
    if (w_shoot) begin
      // Shoot-through wins over everything, including enable=0.
      w_state_nxt = S_FAULT;
      w_cnt_nxt   = '0;
    end else if (!enable && r_state != S_FAULT) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_sh)      w_state_nxt = S_HIGH;
          else if (w_sl) w_state_nxt = S_LOW;
        end
        S_HIGH: begin
          if (!w_sh && !w_sl) begin
            w_state_nxt = S_GAP_H;
            w_cnt_nxt   = CNT_W'(1);
          end else if (!w_sh && w_sl) begin
            // Hard switch with no gap at all: report a zero gap.
            w_state_nxt = S_LOW;
            w_meas      = 1'b1;
          end
        end
        S_GAP_H: begin
          if (w_sl) begin
            w_state_nxt = S_LOW;
            w_meas      = 1'b1;
            w_meas_val  = r_cnt;
            w_cnt_nxt   = '0;
          end else if (w_sh) begin
            // Came back to the same side: not a commutation, discard.
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_LOW: begin
          if (!w_sh && !w_sl) begin
            w_state_nxt = S_GAP_L;
            w_cnt_nxt   = CNT_W'(1);
          end else if (w_sh && !w_sl) begin
            w_state_nxt = S_HIGH;
            w_meas      = 1'b1;
            w_meas_dir  = 1'b1;
          end
        end
        S_GAP_L: begin
          if (w_sh) begin
            w_state_nxt = S_HIGH;
            w_meas      = 1'b1;
            w_meas_dir  = 1'b1;
            w_meas_val  = r_cnt;
            w_cnt_nxt   = '0;
          end else if (w_sl) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_FAULT: begin
          w_cnt_nxt = '0;
          if (fault_clr && !w_sh && !w_sl) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_viol_set = w_meas && (min_dead != '0) && (w_meas_val < min_dead);

  // PWM follows the owning side; gaps hold whatever side was last on.
  always_comb begin
    case (w_state_nxt)
      S_HIGH:           w_pwm_nxt = 1'b1;
      S_GAP_H, S_GAP_L: w_pwm_nxt = r_pwm;
      default:          w_pwm_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_h     <= '0;
      r_sync_l     <= '0;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dead_hl    <= '0;
      r_dead_lh    <= '0;
      r_meas_valid <= 1'b0;
      r_meas_dir   <= 1'b0;
      r_pwm        <= 1'b0;
      r_viol       <= 1'b0;
      r_shoot      <= 1'b0;
    end else begin
      r_sync_h     <= {r_sync_h[SYNC_STAGES-2:0], gate_h};
      r_sync_l     <= {r_sync_l[SYNC_STAGES-2:0], gate_l};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_meas_valid <= w_meas;
      r_pwm        <= w_pwm_nxt;
      if (w_meas) begin
        r_meas_dir <= w_meas_dir;
        if (w_meas_dir) r_dead_lh <= w_meas_val;
        else            r_dead_hl <= w_meas_val;
      end
      // Set beats a simultaneous clear.
      r_viol  <= w_viol_set | (r_viol & ~fault_clr);
      r_shoot <= w_shoot    | (r_shoot & ~fault_clr);
    end
  end

  assign dead_hl     = r_dead_hl;
  assign dead_lh     = r_dead_lh;
  assign meas_valid  = r_meas_valid;
  assign meas_dir    = r_meas_dir;
  assign pwm_rec     = r_pwm;
  assign dead_viol   = r_viol;
  assign shoot_fault = r_shoot;

endmodule

// File: tb/tb_gate_deadtime_monitor.sv
module tb_gate_deadtime_monitor;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, enable, gate_h, gate_l, fault_clr;
  logic [CNT_W-1:0] min_dead;
  logic [CNT_W-1:0] dead_hl, dead_lh;
  logic             meas_valid, meas_dir, pwm_rec, dead_viol, shoot_fault;

  int n_pass = 0;
  int n_tot  = 0;
  int n_meas = 0;
  int base;

  gate_deadtime_monitor #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gate_h(gate_h), .gate_l(gate_l),
    .min_dead(min_dead), .fault_clr(fault_clr), .dead_hl(dead_hl), .dead_lh(dead_lh),
    .meas_valid(meas_valid), .meas_dir(meas_dir), .pwm_rec(pwm_rec),
    .dead_viol(dead_viol), .shoot_fault(shoot_fault)
  );

  always #5 clk = ~clk;

  // Count measurement pulses away from the active edge.
  always @(negedge clk) if (meas_valid === 1'b1) n_meas++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1; step(1); fault_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; gate_h = 1'b0; gate_l = 1'b0;
    fault_clr = 1'b0; min_dead = '0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_dead_hl", dead_hl, 0);
    chk("rst_dead_lh", dead_lh, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_pwm", pwm_rec, 0);
    chk("rst_viol", dead_viol, 0);
    chk("rst_shoot", shoot_fault, 0);

    // H on, 20-cycle gap, L on
    enable = 1'b1; min_dead = 16'd10;
    base = n_meas;
    gate_h = 1'b1; step(4);
    chk("idle_entry_pwm", pwm_rec, 1);
    chk("idle_entry_nomeas", n_meas - base, 0);
    gate_h = 1'b0; step(10);
    chk("gap_pwm_hold", pwm_rec, 1);
    step(10); gate_l = 1'b1; step(4);
    chk("hl20_count", n_meas - base, 1);
    chk("hl20_val", dead_hl, 20);
    chk("hl20_dir", meas_dir, 0);
    chk("hl20_viol", dead_viol, 0);
    chk("hl20_pwm", pwm_rec, 0);

    // L off, 5-cycle gap, H on: too short
    base = n_meas;
    gate_l = 1'b0; step(5); gate_h = 1'b1; step(4);
    chk("lh5_count", n_meas - base, 1);
    chk("lh5_val", dead_lh, 5);
    chk("lh5_dir", meas_dir, 1);
    chk("lh5_viol", dead_viol, 1);
    step(3);
    chk("viol_sticky", dead_viol, 1);
    pulse_clr(); 
    chk("viol_cleared", dead_viol, 0);
    chk("clr_keeps_lh", dead_lh, 5);

    // Zero-gap hard switch H->L
    base = n_meas;
    gate_h = 1'b0; gate_l = 1'b1; step(4);
    chk("hl0_count", n_meas - base, 1);
    chk("hl0_val", dead_hl, 0);
    chk("hl0_viol", dead_viol, 1);
    pulse_clr();

    // Legal 12-cycle L->H gap
    gate_l = 1'b0; step(12); gate_h = 1'b1; step(4);
    chk("lh12_val", dead_lh, 12);
    chk("lh12_viol", dead_viol, 0);

    // Shoot-through from HIGH
    gate_l = 1'b1; step(1); gate_l = 1'b0; step(4);
    chk("shoot_set", shoot_fault, 1);
    chk("shoot_pwm", pwm_rec, 0);
    pulse_clr(); step(4);
    chk("fault_hold_pwm", pwm_rec, 0);
    gate_h = 1'b0; step(4);
    pulse_clr(); step(1);
    chk("shoot_cleared", shoot_fault, 0);
    base = n_meas;
    gate_h = 1'b1; step(4);
    chk("post_fault_idle_pwm", pwm_rec, 1);
    chk("post_fault_nomeas", n_meas - base, 0);

    // Return to same side: no measurement
    base = n_meas;
    gate_h = 1'b0; step(7); gate_h = 1'b1; step(4);
    chk("same_side_nomeas", n_meas - base, 0);
    chk("same_side_hl", dead_hl, 0);
    chk("same_side_pwm", pwm_rec, 1);
    gate_h = 1'b0; step(15); gate_l = 1'b1; step(4);
    chk("hl15_count", n_meas - base, 1);
    chk("hl15_val", dead_hl, 15);

    // Disable during a 30-cycle gap
    base = n_meas;
    gate_l = 1'b0; step(10);
    enable = 1'b0; step(3);
    enable = 1'b1; step(17);
    gate_h = 1'b1; step(4);
    chk("abort_nomeas", n_meas - base, 0);
    chk("abort_lh_kept", dead_lh, 12);
    chk("abort_pwm", pwm_rec, 1);
    gate_h = 1'b0; step(25); gate_l = 1'b1; step(4);
    chk("fresh_count", n_meas - base, 1);
    chk("fresh_val", dead_hl, 25);
    chk("fresh_viol", dead_viol, 0);

    // min_dead = 0 disables the check
    min_dead = '0; base = n_meas;
    gate_l = 1'b0; gate_h = 1'b1; step(4);
    chk("md0_count", n_meas - base, 1);
    chk("md0_val", dead_lh, 0);
    chk("md0_dir", meas_dir, 1);
    chk("md0_viol", dead_viol, 0);

    // Reset in the middle of a gap
    gate_h = 1'b0; step(8);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("midrst_hl", dead_hl, 0);
    chk("midrst_dir", meas_dir, 0);
    chk("midrst_pwm", pwm_rec, 0);
    step(20);
    chk("midrst_nomeas", meas_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
